irq_capture8: RTL
=================

# irq_capture8

Eight-line interrupt capture and round-robin grant stage that feeds the 8:3 binary encoder. It latches rising edges on eight request lines into a pending register and applies a per-line mask. It presents exactly one pending line at a time as a registered one-hot grant, which the downstream encoder converts to a 3-bit index. The grant is held until the consumer acknowledges it, then the line's pending bit is cleared.

## Interface
- POINTER_INIT, default 0: round-robin start index after reset; range 0..7.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  8  raw request lines; a rising edge on bit i requests service for line i.
- irq_mask  input  8  per-line enable; 1 = eligible for grant, 0 = held pending but never granted.
- irq_ack  input  1  consumer accepts the current grant; only meaningful while irq_valid=1.
- grant_onehot  output  8  registered one-hot grant, 8'h00 when idle; drives the encoder's 8-bit data input.
- irq_valid  output  1  grant_onehot is valid and stable.
- pending  output  8  current pending register, for status and debug.

## Operation
- **Reset**:
  - grant_onehot=8'h00, irq_valid=0, pending=8'h00.
  - irq_prev=8'h00, so a line that is already high at reset release counts as an edge.
  - Pointer=POINTER_INIT; state=IDLE.
- **Edge capture**: edge = irq_in & ~irq_prev, evaluated every cycle. At the clock edge, pending |= edge and irq_prev <= irq_in.
- **Eligibility**: elig = pending & irq_mask.
- **Round-robin pick**: the first set bit of elig, searching upward from the pointer and wrapping 7→0.
- **State machine**: two states, IDLE and GRANT.
  - IDLE, elig≠0: load grant_onehot with the picked bit, set irq_valid=1, go to GRANT.
  - IDLE, elig=0: hold.
  - GRANT, irq_ack=1:
    - Clear the granted pending bit, then set grant_onehot=8'h00 and irq_valid=0.
    - Pointer = (granted index + 1) mod 8.
    - Go to IDLE.
  - GRANT, irq_ack=0: hold. grant_onehot stays stable regardless of irq_mask or pending changes.
- **Ack and new edge together**: if the ack cycle coincides with a new edge on the granted line, the edge wins and the pending bit stays 1.
- **Ack outside GRANT**: irq_ack while in IDLE is ignored.
- **Masking**:
  - A masked line keeps its pending bit.
  - Unmasking it later makes it eligible with no new edge needed.
- **Repeated edges**: repeated edges on an already-pending line collapse into one request (no counting).

## Timing
- Rising edge of irq_in sampled at edge k → pending bit set after edge k.
- If IDLE and the line is eligible, irq_valid=1 with the grant after edge k+1, giving a 2-cycle latency from input.
- Ack sampled at edge m → irq_valid=0 after edge m.
- The next grant appears after edge m+1 at the earliest, so there is one idle cycle between grants.
- Sustained back-to-back service of all eight lines takes 2 cycles per grant at minimum.
- Reset asserted mid-grant forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- IRQ_SYNC_EN defined:
  - irq_in passes through a 2-flop synchronizer per bit, reset to 0, before edge detection.
  - Input-to-pending latency grows by 2 cycles, so input-to-valid becomes 4 cycles.
- IRQ_SYNC_EN undefined: irq_in is treated as synchronous to clk and feeds edge detection directly.

## Structure
- **Package irq_pkg**:
  - NUM_IRQ=8 and IDX_W=3.
  - State enum {IDLE, GRANT}.
- **Sub-module rr_pick8**: combinational.
  - Inputs: 8-bit elig and 3-bit pointer.
  - Outputs: 8-bit one-hot pick and a 1-bit any flag.
  - Instantiated once.

## Test plan
- **Reset defaults**: rst pulse with irq_in=8'h00 → grant_onehot=8'h00, irq_valid=0, pending=8'h00. Then pulse irq_in=8'h08 for 1 cycle with mask=8'hFF → pending=8'h08, then grant_onehot=8'h08 with irq_valid=1 2 cycles after the input edge.
- **Round-robin order**: simultaneous edges on irq_in=8'h81 with POINTER_INIT=0, ack every grant → grants 8'h01 then 8'h80. Repeat with pending 8'h81 and pointer=1 → 8'h80 first.
- **Mask hold**: irq_mask=8'hFE, edge on bit 0 → pending=8'h01, no grant. Raise irq_mask[0] → grant 8'h01 one cycle later.
- **Grant stability**: with grant 8'h04 outstanding, hold irq_ack=0 for 10 cycles while new edges arrive on bits 1 and 6 → grant_onehot stays 8'h04 and pending=8'h46.
- **Ack collision**: ack cycle coincides with a new rising edge on the granted bit 2 → pending[2] stays 1 and the line is re-granted after the idle cycle.
- **Async reset mid-grant**: assert rst between clock edges while irq_valid=1 → grant_onehot=8'h00 and irq_valid=0 before the next clk edge. With IRQ_SYNC_EN defined, input-to-valid latency is 4 cycles.

Source files
------------

// File: rtl/irq_capture8_pkg.sv
// irq_pkg: shared constants, FSM state type and a one-hot to index helper
// for the irq_capture8 interrupt capture / round-robin grant block.
// No ports; imported by the interface, rr_pick8 and irq_capture8.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the bit position of a one-hot vector. The input is always a
    // single set bit, so OR-ing the indices is exact.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_IRQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_capture8_if.sv
// irq_capture8_if: groups the request, mask, ack and grant/status signals of
// irq_capture8.
//   irq_in[7:0]        raw request lines (driven by master)
//   irq_mask[7:0]      per-line grant enable (driven by master)
//   irq_ack            consumer accepts the current grant (driven by master)
//   grant_onehot[7:0]  registered one-hot grant (driven by slave)
//   irq_valid          grant_onehot is valid (driven by slave)
//   pending[7:0]       pending register status (driven by slave)
interface irq_capture8_if;
    import irq_pkg::*;

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               irq_ack;
    logic [NUM_IRQ-1:0] grant_onehot;
    logic               irq_valid;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq_in,
        output irq_mask,
        output irq_ack,
        input  grant_onehot,
        input  irq_valid,
        input  pending
    );

    modport slave (
        input  irq_in,
        input  irq_mask,
        input  irq_ack,
        output grant_onehot,
        output irq_valid,
        output pending
    );

endinterface

// File: rtl/irq_capture8_rr_pick8.sv
// rr_pick8: combinational round-robin picker. Finds the first set bit of elig
// searching upward from pointer and wrapping 7 -> 0.
//   elig[7:0]     eligible request lines
//   pointer[2:0]  search start index
//   pick[7:0]     one-hot winner, 8'h00 when nothing is eligible
//   any           at least one line is eligible
module rr_pick8
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] elig,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_IRQ-1:0] pick,
    output logic               any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    assign any = |elig;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            // 3-bit add wraps naturally from 7 back to 0
            idx = pointer + IDX_W'(i);
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_capture8.sv
// irq_capture8: eight-line interrupt capture and round-robin grant stage.
// Rising edges on irq_in set bits of a pending register; masked-in pending
// lines are granted one at a time as a registered one-hot that is held until
// acknowledged, after which the granted pending bit is cleared.
//   clk             system clock
//   rst             asynchronous active-high reset
//   bus (slave)     irq_in, irq_mask, irq_ack in; grant_onehot, irq_valid,
//                   pending out
//   POINTER_INIT    round-robin start index after reset (0..7)
// Build option: define IRQ_SYNC_EN to place a 2-flop synchronizer on each
// irq_in bit ahead of edge detection (adds 2 cycles of input latency).
module irq_capture8
    import irq_pkg::*;
#(
    parameter int POINTER_INIT = 0
)
(
    input  logic           clk,
    input  logic           rst,
    irq_capture8_if.slave  bus
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] pick;
    logic               any;
    logic [NUM_IRQ-1:0] grant_q;
    logic [NUM_IRQ-1:0] grant_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic               ack_take;
    state_t             state_q;
    state_t             state_d;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = bus.irq_in;
`endif

    // irq_prev resets to 0 so a line already high at reset release is an edge
    assign rise     = irq_s & ~irq_prev;
    assign elig     = pending_q & bus.irq_mask;
    assign ack_take = (state_q == GRANT) && bus.irq_ack;

    // Clear is applied before the new edge is OR-ed in, so a fresh edge on the
    // line being acknowledged keeps its pending bit set.
    always_comb begin
        pending_d = pending_q;
        if (ack_take) begin
            pending_d = pending_d & ~grant_q;
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev  <= '0;
            pending_q <= '0;
        end else begin
            irq_prev  <= irq_s;
            pending_q <= pending_d;
        end
    end

    rr_pick8 u_pick (
        .elig    (elig),
        .pointer (ptr_q),
        .pick    (pick),
        .any     (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(POINTER_INIT);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant is only loaded from IDLE, so it stays frozen in GRANT no matter
    // how mask or pending change underneath it.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.irq_ack) begin
                    grant_d = '0;
                    ptr_d   = onehot_to_idx(grant_q) + IDX_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant_onehot = grant_q;
    assign bus.irq_valid    = (state_q == GRANT);
    assign bus.pending      = pending_q;

endmodule
